// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Queue entries carry the PC at a fixed maximum width; users slice down to their ADDR_W.
package if_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned PC_MAX_W = 32;

    localparam logic [6:0] OPC_B_UNCOND = 7'b1100000;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_WAIT,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0]  word;
        logic [PC_MAX_W-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/if_queue2.sv
// Two-entry shift queue: head is always slot 0, flush wins over push/pop.
// Empty slots are forced to zero so decode never sees stale words.
module if_queue2
    import if_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  fq_entry_t entry_i,
    input  logic      pop_i,
    input  logic      flush_i,
    output fq_entry_t head_o,
    output fq_entry_t next_o,
    output logic [1:0] count_o
);

    fq_entry_t  head_q, head_d;
    fq_entry_t  next_q, next_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok;

    assign pop_ok = pop_i && (count_q != 2'd0);

    // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        next_d  = next_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            next_d  = '0;
            count_d = 2'd0;
        end else begin
            unique case ({push_i, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d  = entry_i;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        next_d  = entry_i;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    head_d  = next_q;
                    next_d  = '0;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = entry_i;
                    end else begin
                        head_d = next_q;
                        next_d = entry_i;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the two slots are plain flops, not a RAM, so they take the async reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            next_q  <= '0;
            count_q <= 2'd0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            head_q  <= head_d;
            next_q  <= next_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign next_o  = next_q;
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch stage: owns the PC, talks req/ack to imem, feeds decode a head + lookahead word.
// Define FETCH_BRANCH_PREDECODE_EN to follow unconditional B targets at fetch time.
module if_fetch_queue
    import if_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    input  logic               halt,
    input  logic               id_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] Instruction,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               next_valid,
    output logic [INSTR_W-1:0] Instruction_next,
    output logic               halted
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              halt_pend_q, halt_pend_d;

    logic              req_int;
    logic              unacked;
    logic              pop;
    logic              push;
    logic              flush;
    logic [1:0]        q_count;
    logic [1:0]        count_eff;
    logic [ADDR_W-1:0] next_pc;
    fq_entry_t         q_head, q_next, push_entry;
    logic              pc_hi_unused;

    assign instr_valid = (q_count != 2'd0);
    assign next_valid  = (q_count == 2'd2);
    assign pop         = instr_valid && id_ready;
    assign count_eff   = q_count - {1'b0, pop};
    assign unacked     = req_int && !imem_ack;

`ifdef FETCH_BRANCH_PREDECODE_EN
    logic [ADDR_W+15:0] br_ofs_ext;
    assign br_ofs_ext = {{ADDR_W{imem_rdata[15]}}, imem_rdata[15:0]};
    assign next_pc = (imem_rdata[31:25] == OPC_B_UNCOND) ? imem_addr + br_ofs_ext[ADDR_W-1:0]
                                                         : imem_addr + ADDR_W'(1);
`else
    assign next_pc = imem_addr + ADDR_W'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            halt_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            halt_pend_q <= halt_pend_d;
        end
    end

    // Halt outranks redirect, which outranks the normal fetch/drain flow.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        halt_pend_d = halt_pend_q;
        push        = 1'b0;
        flush       = 1'b0;
        if (unacked) begin
            req_addr_d = imem_addr;
        end
        if (state_q == ST_HALTED) begin
            state_d = ST_HALTED;
        end else if (halt) begin
            flush       = 1'b1;
            halt_pend_d = 1'b1;
            state_d     = unacked ? ST_DRAIN : ST_HALTED;
        end else if (redirect_valid) begin
            flush = 1'b1;
            pc_d  = redirect_target;
            if (unacked) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = halt_pend_q ? ST_HALTED : ST_FETCH;
            end
        end else if (state_q == ST_DRAIN) begin
            if (imem_ack) begin
                state_d = halt_pend_q ? ST_HALTED : ST_FETCH;
            end
        end else if (req_int) begin
            if (imem_ack) begin
                push    = 1'b1;
                pc_d    = next_pc;
                state_d = ST_FETCH;
            end else begin
                state_d = ST_WAIT;
            end
        end
    end

    // An outstanding request keeps its captured address even if the PC is redirected.
    always_comb begin
        req_int   = 1'b0;
        imem_addr = pc_q;
        halted    = 1'b0;
        unique case (state_q)
            ST_FETCH:          req_int = (count_eff < 2'd2);
            ST_WAIT, ST_DRAIN: begin
                req_int   = 1'b1;
                imem_addr = req_addr_q;
            end
            ST_HALTED:         halted = 1'b1;
            default: ;
        endcase
        imem_req = req_int && rst_n;
    end

    assign push_entry = '{word: imem_rdata, pc: PC_MAX_W'(imem_addr)};

    if_queue2 u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (q_head),
        .next_o  (q_next),
        .count_o (q_count)
    );

    assign Instruction      = q_head.word;
    assign instr_pc         = q_head.pc[ADDR_W-1:0];
    assign Instruction_next = q_next.word;
    assign pc_hi_unused     = ^{q_head.pc, q_next.pc};

endmodule
